ws2812_rx: RTL and testbench
============================

Name: ws2812_rx

Overview:
Single-wire WS2812 stream decoder, the receive end of the LED frame transmitter path. It samples the serial data line, measures each high pulse and classifies it as 0 or 1, then assembles 24-bit pixel words in wire order, MSB first. It reports pixel index, end-of-frame on the reset gap, and protocol errors. It is used for loopback self-test of the LED driver chain and for board-level strip emulation.

Parameters:
- CLK_HZ, 50_000_000, system clock; documentation only, all timing is in cycles.
- MIN_HIGH, 5, high pulse shorter than this is a glitch.
- BIT1_THRESH, 30, high width >= this decodes as 1, otherwise 0 (T0H about 20, T1H about 40 at 50 MHz).
- MAX_HIGH, 60, high pulse reaching this count is a stuck-high error.
- RESET_CYCLES, 2500, low time that ends a frame (50 us).
- MAX_PIXELS, 60, pixels accepted per frame.
- IDX_W, 6, pixel index width.
- CNT_W, 16, pulse counter width; must hold RESET_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- din  in  1  asynchronous WS2812 data line.
- pixel  out  24  last decoded word, wire order (GRB).
- pixel_valid  out  1  one-cycle strobe; pixel is valid this cycle.
- pixel_idx  out  IDX_W  index of the pixel currently strobed.
- frame_done  out  1  one-cycle strobe on the reset gap after at least one bit.
- frame_len  out  IDX_W+1  number of complete pixels in the frame; valid with frame_done, then held.
- err_glitch  out  1  one-cycle strobe.
- err_stuck  out  1  one-cycle strobe.
- err_partial  out  1  one-cycle strobe.
- err_overflow  out  1  one-cycle strobe.
- dout  out  1  forwarded stream (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous, active-high. All outputs reset to 0; state resets to SYNC; counters reset to 0.
- Input path: din passes through a 2-flop synchronizer to give din_s. Edges are detected on din_s against its registered copy.
- The state machine has three states: SYNC, LOW and HIGH.
- SYNC:
  - cnt counts while din_s is 0 and clears while din_s is 1.
  - When cnt reaches RESET_CYCLES-1, go to LOW with bit and pixel counters at 0. No frame_done is issued.
- LOW:
  - cnt counts low cycles and saturates.
  - A rising edge sets cnt=1 and moves to HIGH.
  - When cnt reaches RESET_CYCLES-1 with bit_cnt!=0 or pixel_cnt!=0, issue frame_done with frame_len=pixel_cnt.
  - In that same case, also strobe err_partial if bit_cnt!=0, then clear both counters.
  - The gap strobe fires only once per gap.
- HIGH:
  - cnt counts.
  - A falling edge with w=cnt: if w<MIN_HIGH, strobe err_glitch, discard the partial pixel, go to SYNC. Otherwise shift in (w>=BIT1_THRESH) and go to LOW with cnt=0.
  - If cnt reaches MAX_HIGH, strobe err_stuck, discard the partial pixel, go to SYNC.
- On the 24th bit:
  - If pixel_cnt<MAX_PIXELS: load pixel, pixel_valid=1, pixel_idx=pixel_cnt, then pixel_cnt++.
  - Otherwise: err_overflow=1, pixel is unchanged, no pixel_valid.
  - bit_cnt wraps to 0 in both cases.
- Latency: pixel_valid is high 3 clk after the din falling edge of bit 23 (2 synchronizer stages plus 1 register).
- Simultaneous events: a falling edge in the same cycle cnt hits MAX_HIGH is treated as stuck. frame_done and err_partial may coincide.
- Reset mid-frame: the partial pixel is discarded, no strobes are issued, and the block restarts in SYNC.

Optional Feature:
- Macro: WS2812_RX_FORWARD_EN.
- Defined: dout = din_s registered (one cycle later), but forced to 0 while pixel_cnt==0 within the frame, so the first pixel is consumed as in a real LED.
  - Forwarding resumes from the rising edge of bit 0 of pixel 1.
  - dout is 0 in SYNC and after the reset gap.
- Undefined: dout is constant 0 and the forwarding logic is absent.

Decomposition:
- Package ws2812_pkg holds the state enum (SYNC, LOW, HIGH), the timing defaults shared with the transmitter (T0H, T1H, RESET_CYCLES), and PIXEL_W=24.
- One sub-module, ws2812_din_sync: 2-flop synchronizer plus rise/fall edge strobes.

Test Plan:
- Reset gap is 2500 low cycles, then pixel 0x00FF00 sent with 20/40-cycle highs and a 1.25 us period -> pixel_valid once, pixel=0x00FF00, pixel_idx=0, 3 clk after the last falling edge.
- 3 pixels, then 2500 low cycles -> three strobes with idx 0,1,2, then frame_done with frame_len=3.
- 3-cycle high pulse mid-pixel -> err_glitch, no pixel_valid, and the next frame after a gap decodes correctly.
- din held high for 100 cycles -> err_stuck at cnt=60, state SYNC.
- 10 bits then the gap -> err_partial with frame_done and frame_len=0. With 61 pixels -> 60 strobes, err_overflow once, frame_len=60.
- With WS2812_RX_FORWARD_EN, 2 pixels -> dout silent for pixel 0, reproduces pixel 1 delayed 1 clk. Without the macro, dout is always 0.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: receiver state encoding and the timing defaults
// common to the LED transmitter and this receiver (cycles at 50 MHz).
package ws2812_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_e;

  localparam int PIXEL_W      = 24;
  localparam int T0H          = 20;
  localparam int T1H          = 40;
  localparam int RESET_CYCLES = 2500;

endpackage

// File: rtl/ws2812_rx_if.sv
// Serial input and decoded-output bundle of the WS2812 receiver.
// master = receiver (drives decoded outputs), slave = consumer (drives din).
interface ws2812_rx_if #(
  parameter int IDX_W = 6
);
  import ws2812_pkg::*;

  // All outputs are single-cycle strobes with their data valid in the same
  // cycle; there is no ready/backpressure, the consumer must take them as they come.
  logic               din;
  logic [PIXEL_W-1:0] pixel;
  logic               pixel_valid;
  logic [IDX_W-1:0]   pixel_idx;
  logic               frame_done;
  logic [IDX_W:0]     frame_len;
  logic               err_glitch;
  logic               err_stuck;
  logic               err_partial;
  logic               err_overflow;
  logic               dout;
  state_e             state;

  modport master (
    input  din,
    output pixel, pixel_valid, pixel_idx, frame_done, frame_len,
           err_glitch, err_stuck, err_partial, err_overflow, dout, state
  );

  modport slave (
    output din,
    input  pixel, pixel_valid, pixel_idx, frame_done, frame_len,
           err_glitch, err_stuck, err_partial, err_overflow, dout, state
  );

endinterface

// File: rtl/ws2812_din_sync.sv
// Two-flop synchronizer for the asynchronous data line, plus rise/fall
// strobes taken against a registered copy of the synchronized level.
module ws2812_din_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic din_s,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign din_s = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 single-wire decoder: measures high pulses, assembles 24-bit GRB words.
// Optional pass-through of the stream after the first pixel: WS2812_RX_FORWARD_EN.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int MIN_HIGH     = 5,
  parameter int BIT1_THRESH  = 30,
  parameter int MAX_HIGH     = 60,
  parameter int RESET_CYCLES = 2500,
  parameter int MAX_PIXELS   = 60,
  parameter int IDX_W        = 6,
  parameter int CNT_W        = 16
) (
  input  logic         clk,
  input  logic         rst,
  ws2812_rx_if.master  bus
);

  if (CNT_W < $clog2(RESET_CYCLES) || CLK_HZ <= 0) begin : g_cfg_check
    $error("ws2812_rx: CNT_W cannot hold RESET_CYCLES or CLK_HZ is invalid");
  end

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] CNT_BIT1 = CNT_W'(BIT1_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_HIGH);
  localparam logic [IDX_W:0]   PIX_MAX  = (IDX_W + 1)'(MAX_PIXELS);
  localparam logic [4:0]       LAST_BIT = 5'(PIXEL_W - 1);

  logic din_s, rise, fall;

  ws2812_din_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.din),
    .din_s (din_s),
    .rise  (rise),
    .fall  (fall)
  );

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic [IDX_W:0]       pixel_cnt_q, pixel_cnt_d;
  logic [PIXEL_W-2:0]   shift_q, shift_d;
  logic [PIXEL_W-1:0]   pixel_q, pixel_d;
  logic                 pixel_valid_q, pixel_valid_d;
  logic [IDX_W-1:0]     pixel_idx_q, pixel_idx_d;
  logic                 frame_done_q, frame_done_d;
  logic [IDX_W:0]       frame_len_q, frame_len_d;
  logic                 err_glitch_q, err_glitch_d;
  logic                 err_stuck_q, err_stuck_d;
  logic                 err_partial_q, err_partial_d;
  logic                 err_overflow_q, err_overflow_d;

  logic                 shift_en;
  logic                 bit_in;
  logic [PIXEL_W-1:0]   word;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bit_cnt_d      = bit_cnt_q;
    pixel_cnt_d    = pixel_cnt_q;
    shift_d        = shift_q;
    pixel_d        = pixel_q;
    pixel_idx_d    = pixel_idx_q;
    frame_len_d    = frame_len_q;
    pixel_valid_d  = 1'b0;
    frame_done_d   = 1'b0;
    err_glitch_d   = 1'b0;
    err_stuck_d    = 1'b0;
    err_partial_d  = 1'b0;
    err_overflow_d = 1'b0;
    shift_en       = 1'b0;
    bit_in         = 1'b0;
    word           = {shift_q, bit_in};

    case (state_q)
      SYNC: begin
        if (din_s) begin
          cnt_d = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d     = LOW;
          bit_cnt_d   = '0;
          pixel_cnt_d = '0;
          shift_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      LOW: begin
        if (rise) begin
          cnt_d   = CNT_W'(1);
          state_d = HIGH;
        end else if (cnt_q != GAP_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (bit_cnt_q != '0 || pixel_cnt_q != '0) begin
          // Clearing the counters here is what limits the strobe to once per gap.
          frame_done_d  = 1'b1;
          frame_len_d   = pixel_cnt_q;
          err_partial_d = (bit_cnt_q != '0);
          bit_cnt_d     = '0;
          pixel_cnt_d   = '0;
          shift_d       = '0;
        end
      end

      HIGH: begin
        // Stuck wins over a falling edge seen in the same cycle.
        if (cnt_q >= CNT_MAX) begin
          err_stuck_d = 1'b1;
          state_d     = SYNC;
          cnt_d       = '0;
          bit_cnt_d   = '0;
          shift_d     = '0;
        end else if (fall) begin
          cnt_d = '0;
          if (cnt_q < CNT_MIN) begin
            err_glitch_d = 1'b1;
            state_d      = SYNC;
            bit_cnt_d    = '0;
            shift_d      = '0;
          end else begin
            shift_en = 1'b1;
            bit_in   = (cnt_q >= CNT_BIT1);
            state_d  = LOW;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = SYNC;
        cnt_d   = '0;
      end
    endcase

    word = {shift_q, bit_in};
    if (shift_en) begin
      shift_d = word[PIXEL_W-2:0];
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = '0;
        if (pixel_cnt_q < PIX_MAX) begin
          pixel_d       = word;
          pixel_valid_d = 1'b1;
          pixel_idx_d   = pixel_cnt_q[IDX_W-1:0];
          pixel_cnt_d   = pixel_cnt_q + 1'b1;
        end else begin
          err_overflow_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= SYNC;
      cnt_q          <= '0;
      bit_cnt_q      <= '0;
      pixel_cnt_q    <= '0;
      shift_q        <= '0;
      pixel_q        <= '0;
      pixel_valid_q  <= 1'b0;
      pixel_idx_q    <= '0;
      frame_done_q   <= 1'b0;
      frame_len_q    <= '0;
      err_glitch_q   <= 1'b0;
      err_stuck_q    <= 1'b0;
      err_partial_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      pixel_cnt_q    <= pixel_cnt_d;
      shift_q        <= shift_d;
      pixel_q        <= pixel_d;
      pixel_valid_q  <= pixel_valid_d;
      pixel_idx_q    <= pixel_idx_d;
      frame_done_q   <= frame_done_d;
      frame_len_q    <= frame_len_d;
      err_glitch_q   <= err_glitch_d;
      err_stuck_q    <= err_stuck_d;
      err_partial_q  <= err_partial_d;
      err_overflow_q <= err_overflow_d;
    end
  end

`ifdef WS2812_RX_FORWARD_EN
  logic dout_q, dout_d;

  // The first pixel of each frame is consumed, as a real LED would.
  always_comb begin
    dout_d = din_s && (state_q != SYNC) && (pixel_cnt_q != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) dout_q <= 1'b0;
    else     dout_q <= dout_d;
  end

  assign bus.dout = dout_q;
`else
  assign bus.dout = 1'b0;
`endif

  assign bus.pixel        = pixel_q;
  assign bus.pixel_valid  = pixel_valid_q;
  assign bus.pixel_idx    = pixel_idx_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.frame_len    = frame_len_q;
  assign bus.err_glitch   = err_glitch_q;
  assign bus.err_stuck    = err_stuck_q;
  assign bus.err_partial  = err_partial_q;
  assign bus.err_overflow = err_overflow_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: waveform driver tasks, a negedge monitor that
// records strobes, and one task per scenario with inline expected-value checks.
module tb_ws2812_rx;
  import ws2812_pkg::*;

  localparam int IDX_W = 6;
  localparam int GAP   = 2520;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ws2812_rx_if #(.IDX_W(IDX_W)) bus ();

  ws2812_rx #(.IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0]      exp_q[$];
  logic [23:0]      pix_q[$];
  logic [IDX_W-1:0] idx_q[$];
  int               pv_cyc_q[$];

  int             n_fd = 0, n_fd_partial = 0, n_glitch = 0, n_stuck = 0;
  int             n_partial = 0, n_overflow = 0, n_dout_hi = 0, stuck_cyc = 0;
  int             fwd_bad = 0, fwd_mode = 0;
  logic [IDX_W:0] fl_last = '0;
  logic [2:0]     din_hist = '0;
  int             last_fall_cyc = 0;

  always @(posedge clk) din_hist <= {din_hist[1:0], bus.din};

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.pixel_valid) begin
        pix_q.push_back(bus.pixel);
        idx_q.push_back(bus.pixel_idx);
        pv_cyc_q.push_back(cyc);
      end
      if (bus.frame_done) begin
        n_fd    <= n_fd + 1;
        fl_last <= bus.frame_len;
        if (bus.err_partial) n_fd_partial <= n_fd_partial + 1;
      end
      if (bus.err_glitch)   n_glitch   <= n_glitch + 1;
      if (bus.err_stuck) begin
        n_stuck   <= n_stuck + 1;
        stuck_cyc <= cyc;
      end
      if (bus.err_partial)  n_partial  <= n_partial + 1;
      if (bus.err_overflow) n_overflow <= n_overflow + 1;
      if (bus.dout)         n_dout_hi  <= n_dout_hi + 1;
      if (fwd_mode == 1 && bus.dout !== 1'b0)        fwd_bad <= fwd_bad + 1;
      if (fwd_mode == 2 && bus.dout !== din_hist[2]) fwd_bad <= fwd_bad + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_level(input logic v, input int n);
    bus.din = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int t0h, input int t1h, input int period);
    int h;
    int lo;
    h  = b ? t1h : t0h;
    lo = (period - h > 6) ? period - h : 6;
    drive_level(1'b1, h);
    last_fall_cyc = cyc;
    drive_level(1'b0, lo);
  endtask

  task automatic send_pixel(input logic [23:0] v, input int t0h, input int t1h, input int period);
    for (int i = 23; i >= 0; i--) drive_bit(v[i], t0h, t1h, period);
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(i[0], T0H, T1H, 62);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.din = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.pixel !== 24'h0) begin n_fail++; $display("FAIL reset_pixel got=%h exp=000000", bus.pixel); end
    n_checks++; if (bus.pixel_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pixel_valid got=%b exp=0", bus.pixel_valid); end
    n_checks++; if (bus.pixel_idx !== '0) begin n_fail++; $display("FAIL reset_pixel_idx got=%0d exp=0", bus.pixel_idx); end
    n_checks++; if (bus.frame_done !== 1'b0 || bus.frame_len !== '0) begin n_fail++; $display("FAIL reset_frame got=%b/%0d exp=0/0", bus.frame_done, bus.frame_len); end
    n_checks++; if ({bus.err_glitch, bus.err_stuck, bus.err_partial, bus.err_overflow} !== 4'b0) begin
      n_fail++; $display("FAIL reset_errors got=%b exp=0000", {bus.err_glitch, bus.err_stuck, bus.err_partial, bus.err_overflow}); end
    n_checks++; if (bus.state !== SYNC) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", bus.state, SYNC); end
    n_checks++; if (bus.dout !== 1'b0) begin n_fail++; $display("FAIL reset_dout got=%b exp=0", bus.dout); end
    rst = 1'b0;
    drive_level(1'b0, GAP);
    n_checks++; if (bus.state !== LOW) begin n_fail++; $display("FAIL sync_to_low got=%0d exp=%0d", bus.state, LOW); end
    n_checks++; if (n_fd !== 0) begin n_fail++; $display("FAIL sync_no_frame_done got=%0d exp=0", n_fd); end
  endtask

  task automatic test_single_pixel();
    int s = pix_q.size();
    int fd0 = n_fd;
    exp_q.push_back(24'h00FF00);
    send_pixel(24'h00FF00, T0H, T1H, 62);
    n_checks++; if (pix_q.size() - s !== 1) begin n_fail++; $display("FAIL single_count got=%0d exp=1", pix_q.size() - s); end
    if (pix_q.size() - s == 1) begin
      n_checks++; if (pix_q[s] !== exp_q[0]) begin n_fail++; $display("FAIL single_value got=%h exp=%h", pix_q[s], exp_q[0]); end
      n_checks++; if (idx_q[s] !== '0) begin n_fail++; $display("FAIL single_idx got=%0d exp=0", idx_q[s]); end
      n_checks++; if (pv_cyc_q[s] - last_fall_cyc !== 3) begin n_fail++; $display("FAIL single_latency got=%0d exp=3", pv_cyc_q[s] - last_fall_cyc); end
    end
    exp_q.delete();
    drive_level(1'b0, GAP);
    n_checks++; if (n_fd - fd0 !== 1 || fl_last !== 7'd1) begin n_fail++; $display("FAIL single_frame got=%0d/%0d exp=1/1", n_fd - fd0, fl_last); end
  endtask

  task automatic test_three_pixels();
    int s = pix_q.size();
    int fd0 = n_fd;
    int p0 = n_partial;
    int bad = 0;
    logic [23:0] pats [3];
    pats = '{24'h123456, 24'hA5C3F0, 24'h0F0F0F};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pats[i]);
      send_pixel(pats[i], T0H, T1H, 62);
    end
    drive_level(1'b0, GAP);
    n_checks++; if (pix_q.size() - s !== 3) begin n_fail++; $display("FAIL three_count got=%0d exp=3", pix_q.size() - s); end
    if (pix_q.size() - s == 3) begin
      for (int i = 0; i < 3; i++)
        if (pix_q[s+i] !== exp_q[i] || idx_q[s+i] !== IDX_W'(i)) begin
          bad++;
          $display("  entry %0d: got %h idx %0d, exp %h idx %0d", i, pix_q[s+i], idx_q[s+i], exp_q[i], i);
        end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL three_values got=%0d bad exp=0", bad); end
    end
    exp_q.delete();
    n_checks++; if (n_fd - fd0 !== 1 || fl_last !== 7'd3) begin n_fail++; $display("FAIL three_frame got=%0d/%0d exp=1/3", n_fd - fd0, fl_last); end
    n_checks++; if (n_partial !== p0) begin n_fail++; $display("FAIL three_no_partial got=%0d exp=%0d", n_partial, p0); end
  endtask

  task automatic test_bit_threshold();
    int s = pix_q.size();
    int g0 = n_glitch;
    int st0 = n_stuck;
    // widths 29/30 straddle the 0/1 threshold; 5/59 sit just inside the glitch and stuck limits
    send_pixel(24'hC3A55A, 29, 30, 62);
    send_pixel(24'h3C5AA5, 5, 59, 70);
    drive_level(1'b0, GAP);
    n_checks++; if (pix_q.size() - s !== 2) begin n_fail++; $display("FAIL thresh_count got=%0d exp=2", pix_q.size() - s); end
    if (pix_q.size() - s == 2) begin
      n_checks++; if (pix_q[s] !== 24'hC3A55A) begin n_fail++; $display("FAIL thresh_29_30 got=%h exp=c3a55a", pix_q[s]); end
      n_checks++; if (pix_q[s+1] !== 24'h3C5AA5 || idx_q[s+1] !== 6'd1) begin
        n_fail++; $display("FAIL thresh_5_59 got=%h/%0d exp=3c5aa5/1", pix_q[s+1], idx_q[s+1]); end
    end
    n_checks++; if (n_glitch !== g0 || n_stuck !== st0) begin n_fail++; $display("FAIL thresh_no_err got=%0d/%0d exp=%0d/%0d", n_glitch, n_stuck, g0, st0); end
  endtask

  task automatic test_glitch();
    int s = pix_q.size();
    int g0 = n_glitch;
    int fd0 = n_fd;
    send_bits(5);
    drive_level(1'b1, 3);
    drive_level(1'b0, 20);
    n_checks++; if (n_glitch - g0 !== 1) begin n_fail++; $display("FAIL glitch_strobe got=%0d exp=1", n_glitch - g0); end
    n_checks++; if (bus.state !== SYNC) begin n_fail++; $display("FAIL glitch_state got=%0d exp=%0d", bus.state, SYNC); end
    drive_level(1'b0, GAP);
    n_checks++; if (n_fd !== fd0 || pix_q.size() !== s) begin n_fail++; $display("FAIL glitch_silent got=%0d/%0d exp=%0d/%0d", n_fd, pix_q.size(), fd0, s); end
    send_pixel(24'h5A5A5A, T0H, T1H, 62);
    n_checks++; if (pix_q.size() - s !== 1) begin n_fail++; $display("FAIL glitch_recover_count got=%0d exp=1", pix_q.size() - s); end
    if (pix_q.size() - s == 1) begin
      n_checks++; if (pix_q[s] !== 24'h5A5A5A || idx_q[s] !== '0) begin n_fail++; $display("FAIL glitch_recover got=%h/%0d exp=5a5a5a/0", pix_q[s], idx_q[s]); end
    end
    drive_level(1'b0, GAP);
    n_checks++; if (n_fd - fd0 !== 1 || fl_last !== 7'd1) begin n_fail++; $display("FAIL glitch_frame got=%0d/%0d exp=1/1", n_fd - fd0, fl_last); end
  endtask

  task automatic test_stuck();
    int s = pix_q.size();
    int st0 = n_stuck;
    int fd0 = n_fd;
    int r = cyc;
    drive_level(1'b1, 100);
    drive_level(1'b0, 10);
    n_checks++; if (n_stuck - st0 !== 1) begin n_fail++; $display("FAIL stuck_strobe got=%0d exp=1", n_stuck - st0); end
    // rise reaches the FSM 3 cycles after din, then the count runs 1..60
    n_checks++; if (stuck_cyc - r !== 63) begin n_fail++; $display("FAIL stuck_timing got=%0d exp=63", stuck_cyc - r); end
    n_checks++; if (bus.state !== SYNC) begin n_fail++; $display("FAIL stuck_state got=%0d exp=%0d", bus.state, SYNC); end
    drive_level(1'b0, GAP);
    n_checks++; if (bus.state !== LOW || n_fd !== fd0 || pix_q.size() !== s) begin
      n_fail++; $display("FAIL stuck_resync got=%0d/%0d/%0d exp=%0d/%0d/%0d", bus.state, n_fd, pix_q.size(), LOW, fd0, s); end
  endtask

  task automatic test_partial();
    int s = pix_q.size();
    int fd0 = n_fd;
    int p0 = n_partial;
    int fp0 = n_fd_partial;
    send_bits(10);
    drive_level(1'b0, GAP);
    n_checks++; if (n_partial - p0 !== 1) begin n_fail++; $display("FAIL partial_strobe got=%0d exp=1", n_partial - p0); end
    n_checks++; if (n_fd - fd0 !== 1 || n_fd_partial - fp0 !== 1) begin n_fail++; $display("FAIL partial_with_frame got=%0d/%0d exp=1/1", n_fd - fd0, n_fd_partial - fp0); end
    n_checks++; if (fl_last !== 7'd0 || pix_q.size() !== s) begin n_fail++; $display("FAIL partial_len got=%0d/%0d exp=0/%0d", fl_last, pix_q.size(), s); end
  endtask

  task automatic test_reset_midframe();
    int s = pix_q.size();
    int fd0 = n_fd;
    int p0 = n_partial;
    send_bits(12);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive_level(1'b0, 5);
    n_checks++; if (bus.state !== SYNC) begin n_fail++; $display("FAIL midreset_state got=%0d exp=%0d", bus.state, SYNC); end
    drive_level(1'b0, GAP);
    n_checks++; if (n_fd !== fd0 || n_partial !== p0 || pix_q.size() !== s) begin
      n_fail++; $display("FAIL midreset_silent got=%0d/%0d/%0d exp=%0d/%0d/%0d", n_fd, n_partial, pix_q.size(), fd0, p0, s); end
  endtask

  task automatic test_overflow();
    int s = pix_q.size();
    int o0 = n_overflow;
    int fd0 = n_fd;
    int bad = 0;
    for (int i = 0; i < 60; i++) send_pixel(24'(i), 8, 32, 14);
    send_pixel(24'hFFFFFF, 8, 32, 14);
    n_checks++; if (pix_q.size() - s !== 60) begin n_fail++; $display("FAIL ovf_count got=%0d exp=60", pix_q.size() - s); end
    if (pix_q.size() - s == 60) begin
      for (int i = 0; i < 60; i++)
        if (pix_q[s+i] !== 24'(i) || idx_q[s+i] !== IDX_W'(i)) bad++;
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL ovf_values got=%0d bad exp=0", bad); end
    end
    n_checks++; if (n_overflow - o0 !== 1) begin n_fail++; $display("FAIL ovf_strobe got=%0d exp=1", n_overflow - o0); end
    n_checks++; if (bus.pixel !== 24'd59) begin n_fail++; $display("FAIL ovf_pixel_held got=%h exp=00003b", bus.pixel); end
    drive_level(1'b0, GAP);
    n_checks++; if (n_fd - fd0 !== 1 || fl_last !== 7'd60) begin n_fail++; $display("FAIL ovf_frame got=%0d/%0d exp=1/60", n_fd - fd0, fl_last); end
  endtask

`ifdef WS2812_RX_FORWARD_EN
  task automatic test_forward();
    int h0;
    int h1;
    fwd_mode = 1;
    h0 = n_dout_hi;
    send_pixel(24'h00FF00, T0H, T1H, 62);
    h1 = n_dout_hi;
    fwd_mode = 2;
    send_pixel(24'hA5C3F0, T0H, T1H, 62);
    fwd_mode = 0;
    n_checks++; if (h1 !== h0) begin n_fail++; $display("FAIL fwd_first_silent got=%0d exp=%0d", h1, h0); end
    n_checks++; if (n_dout_hi - h1 !== 12 * 20 + 12 * 40) begin n_fail++; $display("FAIL fwd_high_cycles got=%0d exp=720", n_dout_hi - h1); end
    n_checks++; if (fwd_bad !== 0) begin n_fail++; $display("FAIL fwd_waveform got=%0d bad exp=0", fwd_bad); end
    drive_level(1'b0, GAP);
  endtask
`else
  task automatic test_dout_idle();
    n_checks++; if (n_dout_hi !== 0) begin n_fail++; $display("FAIL dout_idle got=%0d exp=0", n_dout_hi); end
  endtask
`endif

  initial begin
    bus.din = 1'b0;
    test_reset();
    test_single_pixel();
    test_three_pixels();
    test_bit_threshold();
    test_glitch();
    test_stuck();
    test_partial();
    test_reset_midframe();
    test_overflow();
`ifdef WS2812_RX_FORWARD_EN
    test_forward();
`else
    test_dout_idle();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
